// File: rtl/vscale_md_pkg.sv
// Shared multiply/divide encodings for the vscale M-extension issue logic and the unit it drives.
package vscale_md_pkg;

  localparam int XPR_LEN = 32;

  localparam int MD_OP_WIDTH = 2;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_MUL = 2'd0;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV = 2'd1;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_REM = 2'd2;

  localparam int MD_OUT_SEL_WIDTH = 2;
  localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_LO  = 2'd0;
  localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_HI  = 2'd1;
  localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_REM = 2'd2;

  localparam logic [2:0] MD_FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] MD_FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] MD_FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] MD_FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] MD_FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] MD_FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] MD_FUNCT3_REM    = 3'b110;
  localparam logic [2:0] MD_FUNCT3_REMU   = 3'b111;

  // Most negative XPR value: the dividend that overflows signed division by -1.
  localparam logic [XPR_LEN-1:0] XPR_MIN = {1'b1, {(XPR_LEN-1){1'b0}}};

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_ISSUE,
    MD_WAIT,
    MD_WB
  } md_state_e;

  typedef struct packed {
    logic [MD_OP_WIDTH-1:0]      op;
    logic [MD_OUT_SEL_WIDTH-1:0] out_sel;
    logic                        in_1_signed;
    logic                        in_2_signed;
  } md_ctrl_t;

  function automatic logic md_is_div_rem(input logic [MD_OP_WIDTH-1:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

endpackage

// File: rtl/vscale_md_decode.sv
// Combinational RV32M funct3 decode into the multiply/divide unit's control encoding.
module vscale_md_decode
  import vscale_md_pkg::*;
(
  input  logic [2:0] funct3_i,
  output md_ctrl_t   ctrl_o
);

  always_comb begin
    ctrl_o = '{op: MD_OP_MUL, out_sel: MD_OUT_LO, in_1_signed: 1'b0, in_2_signed: 1'b0};
    case (funct3_i)
      MD_FUNCT3_MUL:    ctrl_o = '{op: MD_OP_MUL, out_sel: MD_OUT_LO,  in_1_signed: 1'b0, in_2_signed: 1'b0};
      MD_FUNCT3_MULH:   ctrl_o = '{op: MD_OP_MUL, out_sel: MD_OUT_HI,  in_1_signed: 1'b1, in_2_signed: 1'b1};
      MD_FUNCT3_MULHSU: ctrl_o = '{op: MD_OP_MUL, out_sel: MD_OUT_HI,  in_1_signed: 1'b1, in_2_signed: 1'b0};
      MD_FUNCT3_MULHU:  ctrl_o = '{op: MD_OP_MUL, out_sel: MD_OUT_HI,  in_1_signed: 1'b0, in_2_signed: 1'b0};
      MD_FUNCT3_DIV:    ctrl_o = '{op: MD_OP_DIV, out_sel: MD_OUT_LO,  in_1_signed: 1'b1, in_2_signed: 1'b1};
      MD_FUNCT3_DIVU:   ctrl_o = '{op: MD_OP_DIV, out_sel: MD_OUT_LO,  in_1_signed: 1'b0, in_2_signed: 1'b0};
      MD_FUNCT3_REM:    ctrl_o = '{op: MD_OP_REM, out_sel: MD_OUT_REM, in_1_signed: 1'b1, in_2_signed: 1'b1};
      MD_FUNCT3_REMU:   ctrl_o = '{op: MD_OP_REM, out_sel: MD_OUT_REM, in_1_signed: 1'b0, in_2_signed: 1'b0};
      default:          ctrl_o = '{op: MD_OP_MUL, out_sel: MD_OUT_LO,  in_1_signed: 1'b0, in_2_signed: 1'b0};
    endcase
  end

endmodule

// File: rtl/vscale_md_issue.sv
// Pipeline-side initiator for the multiply/divide unit: decode, request handshake, result hold
// until writeback, local resolution of divide-by-zero/overflow, and kill handling.
module vscale_md_issue
  import vscale_md_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        reset_n_i,

  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic [2:0]                  cmd_funct3_i,
  input  logic [XPR_LEN-1:0]          cmd_rs1_i,
  input  logic [XPR_LEN-1:0]          cmd_rs2_i,
  input  logic [4:0]                  cmd_rd_i,
  input  logic                        kill_i,

  output logic                        req_valid_o,
  input  logic                        req_ready_i,
  output logic                        req_in_1_signed_o,
  output logic                        req_in_2_signed_o,
  output logic [MD_OP_WIDTH-1:0]      req_op_o,
  output logic [MD_OUT_SEL_WIDTH-1:0] req_out_sel_o,
  output logic [XPR_LEN-1:0]          req_in_1_o,
  output logic [XPR_LEN-1:0]          req_in_2_o,

  input  logic                        resp_valid_i,
  input  logic [XPR_LEN-1:0]          resp_result_i,

  output logic                        wb_valid_o,
  input  logic                        wb_ready_i,
  output logic [XPR_LEN-1:0]          wb_data_o,
  output logic [4:0]                  wb_rd_o
);

  md_state_e            state_q, state_d;
  logic                 killed_q, killed_d;
  md_ctrl_t             ctrl_q, ctrl_d;
  logic [XPR_LEN-1:0]   in_1_q, in_1_d;
  logic [XPR_LEN-1:0]   in_2_q, in_2_d;
  logic [4:0]           rd_q, rd_d;
  logic [XPR_LEN-1:0]   result_q, result_d;

  md_ctrl_t             cmd_ctrl;
  logic                 cmd_fire;
  logic                 div_by_zero;
  logic                 div_overflow;
  logic [XPR_LEN-1:0]   special_result;

  vscale_md_decode u_decode (
    .funct3_i (cmd_funct3_i),
    .ctrl_o   (cmd_ctrl)
  );

  assign cmd_fire = cmd_valid_i && cmd_ready_o && !kill_i;

  // Cases the unit is never asked to handle; their RISC-V results are fixed constants or rs1.
  assign div_by_zero  = md_is_div_rem(cmd_ctrl.op) && (cmd_rs2_i == '0);
  assign div_overflow = md_is_div_rem(cmd_ctrl.op) && cmd_ctrl.in_1_signed &&
                        (cmd_rs1_i == XPR_MIN) && (cmd_rs2_i == '1);

  always_comb begin
    special_result = '0;
    if (div_by_zero) begin
      special_result = (cmd_ctrl.op == MD_OP_REM) ? cmd_rs1_i : '1;
    end else if (div_overflow) begin
      special_result = (cmd_ctrl.op == MD_OP_REM) ? '0 : XPR_MIN;
    end
  end

  always_comb begin
    state_d  = state_q;
    killed_d = killed_q;
    ctrl_d   = ctrl_q;
    in_1_d   = in_1_q;
    in_2_d   = in_2_q;
    rd_d     = rd_q;
    result_d = result_q;
    case (state_q)
      MD_IDLE: begin
        if (cmd_fire) begin
          ctrl_d   = cmd_ctrl;
          in_1_d   = cmd_rs1_i;
          in_2_d   = cmd_rs2_i;
          rd_d     = cmd_rd_i;
          killed_d = 1'b0;
          if (div_by_zero || div_overflow) begin
            result_d = special_result;
            state_d  = MD_WB;
          end else begin
            state_d  = MD_ISSUE;
          end
        end
      end
      MD_ISSUE: begin
        if (kill_i) begin
          state_d = MD_IDLE;
        end else if (req_ready_i) begin
          state_d = MD_WAIT;
        end
      end
      // The unit cannot be aborted, so a kill here only marks the eventual response for discard.
      MD_WAIT: begin
        if (resp_valid_i) begin
          if (killed_q || kill_i) begin
            killed_d = 1'b0;
            state_d  = MD_IDLE;
          end else begin
            result_d = resp_result_i;
            state_d  = MD_WB;
          end
        end else if (kill_i) begin
          killed_d = 1'b1;
        end
      end
      MD_WB: begin
        if (kill_i || wb_ready_i) begin
          state_d = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= MD_IDLE;
      killed_q <= 1'b0;
      ctrl_q   <= '0;
      in_1_q   <= '0;
      in_2_q   <= '0;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      killed_q <= killed_d;
      ctrl_q   <= ctrl_d;
      in_1_q   <= in_1_d;
      in_2_q   <= in_2_d;
      rd_q     <= rd_d;
      result_q <= result_d;
    end
  end

  // A kill arriving in ISSUE suppresses req_valid that same cycle so the unit never starts.
  assign cmd_ready_o       = (state_q == MD_IDLE);
  assign req_valid_o       = (state_q == MD_ISSUE) && !kill_i;
  assign req_op_o          = ctrl_q.op;
  assign req_out_sel_o     = ctrl_q.out_sel;
  assign req_in_1_signed_o = ctrl_q.in_1_signed;
  assign req_in_2_signed_o = ctrl_q.in_2_signed;
  assign req_in_1_o        = in_1_q;
  assign req_in_2_o        = in_2_q;
  assign wb_valid_o        = (state_q == MD_WB);
  assign wb_data_o         = result_q;
  assign wb_rd_o           = rd_q;

endmodule

// File: doc/vscale_md_issue.md
Name: vscale_md_issue

Overview:
- Initiator side of the multiply/divide request/response interface.
- Accepts one decoded RV32M instruction from the pipeline (funct3, rs1/rs2 values, rd) and translates it to the unit's op, out_sel and signedness encoding.
- Drives the req handshake, waits for the single-cycle response, and holds the result until writeback accepts it.
- Resolves divide-by-zero and signed overflow locally without engaging the unit, and handles pipeline kill while a request is in flight.

Parameters:
XPR_LEN, 32, datapath width; also the width of rs1, rs2, result and wb_data.

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous, active-low reset
cmd_valid  input  1  pipeline presents an M-extension instruction
cmd_ready  output  1  block can accept a command (state IDLE)
cmd_funct3  input  3  RV32M funct3
cmd_rs1  input  XPR_LEN  operand 1
cmd_rs2  input  XPR_LEN  operand 2
cmd_rd  input  5  destination register
kill  input  1  flush of the current instruction
req_valid  output  1  request to the multiply/divide unit
req_ready  input  1  unit idle, ready to accept
req_in_1_signed  output  1  operand 1 is signed
req_in_2_signed  output  1  operand 2 is signed
req_op  output  MD_OP_WIDTH  MUL / DIV / REM
req_out_sel  output  MD_OUT_SEL_WIDTH  LO / HI / REM
req_in_1  output  XPR_LEN  operand 1
req_in_2  output  XPR_LEN  operand 2
resp_valid  input  1  one-cycle result strobe; no backpressure
resp_result  input  XPR_LEN  result
wb_valid  output  1  result available for writeback
wb_ready  input  1  writeback accepts the result
wb_data  output  XPR_LEN  result
wb_rd  output  5  destination register

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (reset_n). Reset forces state IDLE and clears the killed flag, the operand registers and the result register.
- Output values during reset: req_valid=0, wb_valid=0, cmd_ready=1, all data outputs 0.
- States: IDLE, ISSUE, WAIT, WB.
- Accept condition: a command is accepted when cmd_valid && cmd_ready && !kill. The block then latches the decoded fields, operands and rd.
- Decode (op, out_sel, s1, s2):
  - 000: MUL, LO, 0, 0
  - 001: MUL, HI, 1, 1
  - 010: MUL, HI, 1, 0
  - 011: MUL, HI, 0, 0
  - 100: DIV, LO, 1, 1
  - 101: DIV, LO, 0, 0
  - 110: REM, REM, 1, 1
  - 111: REM, REM, 0, 0
- Short-circuit on accept: if op is DIV or REM and rs2==0, or signed op with rs1==0x80000000 and rs2==0xFFFFFFFF, the block goes IDLE->WB directly and req_valid never asserts. Results:
  - div-by-zero: DIV/DIVU = 0xFFFFFFFF; REM/REMU = rs1.
  - overflow: DIV = 0x80000000; REM = 0.
- Otherwise IDLE->ISSUE.
- ISSUE:
  - req_valid=1; req_* outputs come from registers and stay stable until the handshake completes.
  - req_valid && req_ready -> WAIT.
  - kill -> IDLE; no request is issued.
- WAIT:
  - On resp_valid, capture resp_result and go to WB.
  - kill in WAIT sets the killed flag. The in-flight operation cannot be aborted, so on resp_valid with killed set the result is discarded and the block goes to IDLE.
  - kill and resp_valid in the same cycle: the result is discarded.
- WB:
  - wb_valid=1; wb_data and wb_rd are held stable.
  - wb_ready -> IDLE.
  - kill -> IDLE with no writeback; kill takes priority over wb_ready.
- Latency:
  - Issued op: first wb_valid cycle = resp_valid cycle + 1.
  - Short-circuit: wb_valid in the cycle after accept.
- Back-to-back: cmd_ready rises in the cycle after the WB handshake. Minimum spacing for short-circuit ops is 2 cycles.
- resp_valid outside WAIT is a protocol error; the block ignores it and the bench asserts on it.

Decomposition:
- Shared constants header, reused by the unit:
  - MD_OP_WIDTH, MD_OP_MUL/DIV/REM
  - MD_OUT_SEL_WIDTH, MD_OUT_LO/HI/REM
  - XPR_LEN
  - RV32M funct3 constants
- One combinational sub-module, vscale_md_decode: funct3 -> {op, out_sel, s1, s2}.
- The special-case detect logic stays inline in vscale_md_issue.

Test Plan:
- MUL, rs1=7, rs2=0xFFFFFFFD -> one req with op=MUL, out_sel=LO; resp 0xFFFFFFEB -> wb_data=0xFFFFFFEB, wb_rd matches cmd_rd.
- MULHU, rs1=rs2=0xFFFFFFFF -> req_in_1_signed=0, req_in_2_signed=0, out_sel=HI; wb_data=0xFFFFFFFE.
- DIV, rs1=0xFFFFFFF9, rs2=0 -> no req_valid ever; wb_valid next cycle with 0xFFFFFFFF. Same operands with REM -> 0xFFFFFFF9.
- REM, rs1=0x80000000, rs2=0xFFFFFFFF -> no req; wb_data=0. DIV with the same operands -> 0x80000000.
- DIVU 100/7 with kill asserted in WAIT -> resp 14 discarded, wb_valid stays 0, cmd_ready returns the cycle after resp_valid.
- REMU 100/7 with wb_ready held 0 for 5 cycles -> wb_valid, wb_data=2 and wb_rd stay stable; cmd_ready=0 throughout. reset_n pulsed low mid-WAIT -> immediate IDLE, all outputs at reset values.
